// File: rtl/clk_div_pkg.sv
// Shared defaults and channel state type for the multi-channel clock divider.
package clk_div_pkg;

  localparam int CNT_W_DEF   = 16;
  localparam int DIV_RST_DEF = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_t;

endpackage

// File: rtl/multi_clk_div_if.sv
// Control/status bundle of the multi-channel clock divider.
interface multi_clk_div_if
  import clk_div_pkg::*;
#(
  parameter int N_CH  = 6,
  parameter int CNT_W = CNT_W_DEF
);

  logic [N_CH-1:0]       en;
  logic [N_CH*CNT_W-1:0] div_in;
  logic                  load;
  logic                  sync;
  logic [N_CH-1:0]       clk_out;
  logic [N_CH-1:0]       tick;
  logic [N_CH-1:0]       pending;

  modport master (
    output en, div_in, load, sync,
    input  clk_out, tick, pending
  );

  modport slave (
    input  en, div_in, load, sync,
    output clk_out, tick, pending
  );

endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: shadow/active divisor, period counter, run FSM.
// Outputs are computed from next-state values so they are plain flop Q's.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div,
  input  logic             load,
  input  logic             sync,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_RST);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  ch_state_t        state_reg, state_next;
  logic [CNT_W-1:0] s_reg, s_next;
  logic [CNT_W-1:0] d_reg, d_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W:0]   high_next;
  logic             active_next;
  logic             wrap;
  logic             clk_out_reg, tick_reg, pending_reg;

  always_comb begin
    s_next     = load ? div : s_reg;
    state_next = state_reg;
    d_next     = d_reg;
    cnt_next   = cnt_reg;
    wrap       = (cnt_reg == (d_reg - ONE));
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (en) begin
          state_next = RUN;
          d_next     = s_next;
        end
      end
      RUN: begin
        if (!en) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (sync) begin
          // A sync restart picks up a divisor loaded on the same edge.
          cnt_next = '0;
          d_next   = s_next;
        end else if ((d_reg == '0) || wrap) begin
          // Stopped channels treat every edge as a period boundary.
          cnt_next = '0;
          d_next   = s_reg;
        end else begin
          cnt_next = cnt_reg + ONE;
        end
      end
      default: state_next = IDLE;
    endcase

    high_next   = ({1'b0, d_next} + (CNT_W+1)'(1)) >> 1;
    active_next = (state_next == RUN) && (d_next != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      s_reg       <= DIV_INIT;
      d_reg       <= DIV_INIT;
      cnt_reg     <= '0;
      clk_out_reg <= 1'b0;
      tick_reg    <= 1'b0;
      pending_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      s_reg       <= s_next;
      d_reg       <= d_next;
      cnt_reg     <= cnt_next;
      clk_out_reg <= active_next && ({1'b0, cnt_next} < high_next);
      tick_reg    <= active_next && (cnt_next == '0);
      pending_reg <= (s_next != d_next);
    end
  end

  assign clk_out = clk_out_reg;
  assign tick    = tick_reg;
  assign pending = pending_reg;

endmodule

// File: rtl/multi_clk_div.sv
// N_CH independent programmable clock dividers sharing load/sync strobes.
module multi_clk_div
  import clk_div_pkg::*;
#(
  parameter int N_CH    = 6,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic            clkin,
  input  logic            rst_n,
  multi_clk_div_if.slave  bus
);

  logic [CNT_W-1:0] div_arr [N_CH];
  logic [N_CH-1:0]  clk_out_w, tick_w, pending_w;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign div_arr[gi] = bus.div_in[gi*CNT_W +: CNT_W];

      clk_div_ch #(
        .CNT_W   (CNT_W),
        .DIV_RST (DIV_RST)
      ) u_ch (
        .clk     (clkin),
        .rst_n   (rst_n),
        .en      (bus.en[gi]),
        .div     (div_arr[gi]),
        .load    (bus.load),
        .sync    (bus.sync),
        .clk_out (clk_out_w[gi]),
        .tick    (tick_w[gi]),
        .pending (pending_w[gi])
      );
    end
  endgenerate

  assign bus.clk_out = clk_out_w;
  assign bus.tick    = tick_w;
  assign bus.pending = pending_w;

endmodule

// File: tb/tb_multi_clk_div.sv
// Directed + random bench for multi_clk_div against a period-position model.
module tb_multi_clk_div;

  localparam int N = 6;
  localparam int W = 16;

  logic clkin;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;

  multi_clk_div_if #(.N_CH(N), .CNT_W(W)) bus ();

  multi_clk_div #(.N_CH(N), .CNT_W(W), .DIV_RST(2)) dut (
    .clkin (clkin),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  // Model: each channel is either stopped or some number of cycles into a
  // period of length d; waveform follows from that position directly.
  int m_run [N];
  int m_s   [N];
  int m_d   [N];
  int m_pos [N];
  int dv    [N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_run[i] = 0; m_s[i] = 2; m_d[i] = 2; m_pos[i] = 0;
    end
  endtask

  task automatic drive_div();
    for (int i = 0; i < N; i++) bus.div_in[i*W +: W] = W'(dv[i]);
  endtask

  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      int s_new;
      s_new = bus.load ? dv[i] : m_s[i];
      if (m_run[i] == 0) begin
        if (bus.en[i]) begin m_run[i] = 1; m_d[i] = s_new; m_pos[i] = 0; end
      end else if (!bus.en[i]) begin
        m_run[i] = 0; m_pos[i] = 0;
      end else if (bus.sync) begin
        m_pos[i] = 0; m_d[i] = s_new;
      end else if (m_d[i] == 0) begin
        m_d[i] = m_s[i];
      end else begin
        m_pos[i] = m_pos[i] + 1;
        if (m_pos[i] >= m_d[i]) begin m_pos[i] = 0; m_d[i] = m_s[i]; end
      end
      m_s[i] = s_new;
    end
  endtask

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
    end
  endtask

  task automatic check_all();
    logic [N-1:0] e_clk, e_tick, e_pend;
    for (int i = 0; i < N; i++) begin
      e_clk[i]  = (m_run[i] != 0) && (m_d[i] != 0) && (m_pos[i] < (m_d[i] + 1) / 2);
      e_tick[i] = (m_run[i] != 0) && (m_d[i] != 0) && (m_pos[i] == 0);
      e_pend[i] = (m_s[i] != m_d[i]);
    end
    check("clk_out", bus.clk_out, e_clk);
    check("tick", bus.tick, e_tick);
    check("pending", bus.pending, e_pend);
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clkin);
      model_edge();
      #1;
      cyc++;
      check_all();
      bus.load = 1'b0;
      bus.sync = 1'b0;
    end
  endtask

  task automatic load_divs();
    drive_div();
    bus.load = 1'b1;
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    total = 0; bad = 0; cyc = 0;
    rst_n = 1'b0;
    bus.en = '0; bus.load = 1'b0; bus.sync = 1'b0;
    for (int i = 0; i < N; i++) dv[i] = 2;
    drive_div();
    model_reset();
    repeat (3) @(posedge clkin);
    #1;
    check("rst_clk_out", bus.clk_out, '0);
    check("rst_tick", bus.tick, '0);
    check("rst_pending", bus.pending, '0);
    rst_n = 1'b1;
    step(2);

    // All channels at the reset divisor of 2.
    bus.en = '1;
    step(1);
    check("en_latency_tick", bus.tick, '1);
    step(7);

    // ch0 -> 5, ch1 -> 4.
    dv[0] = 5; dv[1] = 4;
    load_divs();
    step(14);

    // ch1: reload 6 one cycle into a period of 4.
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (m_pos[1] == 1 && m_d[1] == 4) found = 1'b1;
      else step(1);
    end
    check("ch1_phase_found", {{(N-1){1'b0}}, found}, {{(N-1){1'b0}}, 1'b1});
    dv[1] = 6;
    load_divs();
    step(14);

    // ch0=3, ch1=7 drift out of phase, then sync realigns them.
    dv[0] = 3; dv[1] = 7;
    load_divs();
    step(11);
    bus.sync = 1'b1;
    step(1);
    check("sync_tick01", bus.tick & N'(3), N'(3));
    check("sync_clk01", bus.clk_out & N'(3), N'(3));
    step(10);

    // ch2: divisor 0 stops it, divisor 1 holds it high.
    dv[2] = 0;
    load_divs();
    step(8);
    check("d0_clk_ch2", bus.clk_out & N'(4), '0);
    dv[2] = 1;
    load_divs();
    step(4);
    check("d1_clk_ch2", bus.clk_out & N'(4), N'(4));
    check("d1_tick_ch2", bus.tick & N'(4), N'(4));

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(15) == 0) bus.en[i] = ~bus.en[i];
      if ($urandom_range(11) == 0) begin
        for (int i = 0; i < N; i++) dv[i] = $urandom_range(9);
        drive_div();
        bus.load = 1'b1;
      end
      if ($urandom_range(24) == 0) bus.sync = 1'b1;
      step(1);
    end

    // Asynchronous reset pulse in the middle of a cycle.
    bus.en = '1;
    for (int i = 0; i < N; i++) dv[i] = 5;
    load_divs();
    step(3);
    rst_n = 1'b0;
    #2;
    model_reset();
    check("async_rst_clk", bus.clk_out, '0);
    check("async_rst_tick", bus.tick, '0);
    check("async_rst_pend", bus.pending, '0);
    #3;
    rst_n = 1'b1;
    bus.en = '0;
    step(3);
    bus.en = '1;
    step(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
